// File: rtl/led_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : led_arbiter
// Brief    : Round-robin arbiter giving one of four requesters ownership of
//            an 8-LED display for a minimum dwell time, then holding the
//            owner until another requester wants the display.
//            Optional macro LED_ARB_ERR_OVERRIDE_EN adds an error override
//            that blanks the grant and blinks an error pattern.
// Revision : 1.0 - initial release
// ============================================================================
module led_arbiter #(
    parameter int   CLK_IN_MHZ   = 125,
    parameter logic LED_POLARITY = 1'b0,
    parameter int   DWELL_MS     = 500
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [3:0]  req_i,
    input  logic [31:0] pat_i,
`ifdef LED_ARB_ERR_OVERRIDE_EN
    input  logic        err_i,
    input  logic [7:0]  err_pat_i,
`endif
    output logic [3:0]  gnt_o,
    output logic [7:0]  display_o
);

    localparam int               c_prescale   = CLK_IN_MHZ * 1000;
    localparam int               c_pre_w      = (c_prescale > 1) ? $clog2(c_prescale) : 1;
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(c_prescale - 1);
    localparam logic [15:0]      c_dwell_max  = 16'(DWELL_MS);
    localparam logic [15:0]      c_dwell_last = 16'(DWELL_MS - 1);
    // XOR mask turning a "1 = lit" pattern into the physical drive level
    localparam logic [7:0]       c_pol_mask   = LED_POLARITY ? 8'h00 : 8'hFF;
    localparam logic [7:0]       c_leds_off   = c_pol_mask;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           gnt_q, gnt_d;
    logic [1:0]           last_owner_q, last_owner_d;
    logic [c_pre_w-1:0]   pre_q, pre_d;
    logic [15:0]          dwell_q, dwell_d;
    logic [7:0]           display_q, display_d;

    logic                 w_any_vld, w_oth_vld, w_pick_vld;
    logic [1:0]           w_any_idx, w_oth_idx, w_pick_idx;
    logic                 w_owner_req, w_tick, w_expire, w_new_grant;
    logic [7:0]           w_owner_pat;

    // Returns {found, index}: first set bit searching from last+1 (mod 4)
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic       found;
        logic [1:0] idx;
        logic [1:0] pick;
        found = 1'b0;
        pick  = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return {found, pick};
    endfunction

    assign {w_any_vld, w_any_idx} = rr_pick(req_i, last_owner_q);
    // The owner sits last in the search order, so masking it out yields the
    // round-robin winner among the other requesters.
    assign {w_oth_vld, w_oth_idx} = rr_pick(req_i & ~gnt_q, last_owner_q);
    assign w_owner_req = |(req_i & gnt_q);
    assign w_tick      = (pre_q == c_pre_last);
    // Final ms tick of the dwell: handover happens on this very edge so the
    // owner keeps the grant for exactly DWELL_MS*CLK_IN_MHZ*1000 cycles.
    assign w_expire    = w_tick && (dwell_q == c_dwell_last);
    assign w_owner_pat = pat_i[8*last_owner_q +: 8];

    // Next-state, grant and ownership decision
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_owner_d = last_owner_q;
        w_new_grant  = 1'b0;
        w_pick_vld   = 1'b0;
        w_pick_idx   = 2'd0;
        case (state_q)
            IDLE: begin
                w_pick_vld = w_any_vld;
                w_pick_idx = w_any_idx;
            end
            DWELL, HOLD: begin
                if (!w_owner_req) begin
                    w_pick_vld = w_any_vld;
                    w_pick_idx = w_any_idx;
                    if (!w_any_vld) begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                    end
                end else if (state_q == HOLD || w_expire) begin
                    w_pick_vld = w_oth_vld;
                    w_pick_idx = w_oth_idx;
                    if (!w_oth_vld) begin
                        state_d = HOLD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
        if (w_pick_vld) begin
            state_d      = DWELL;
            gnt_d        = 4'b0001 << w_pick_idx;
            last_owner_d = w_pick_idx;
            w_new_grant  = 1'b1;
        end
`ifdef LED_ARB_ERR_OVERRIDE_EN
        if (err_i) begin
            state_d      = IDLE;
            gnt_d        = 4'b0000;
            last_owner_d = last_owner_q;
            w_new_grant  = 1'b0;
        end
`endif
    end

    // ms prescaler restarts on each grant; dwell counter saturates
    always_comb begin
        pre_d   = pre_q + 1'b1;
        dwell_d = dwell_q;
        if (w_new_grant) begin
            pre_d   = '0;
            dwell_d = 16'd0;
        end else if (w_tick) begin
            pre_d = '0;
            if (dwell_q != c_dwell_max) begin
                dwell_d = dwell_q + 16'd1;
            end
        end
    end

`ifdef LED_ARB_ERR_OVERRIDE_EN
    localparam int                 c_blink_half = 250 * c_prescale;
    localparam int                 c_blink_w    = $clog2(c_blink_half);
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(c_blink_half - 1);

    logic                 err_q;
    logic [c_blink_w-1:0] blink_cnt_q, blink_cnt_d;
    logic                 blink_on_q, blink_on_d;

    // 250 ms on / 250 ms off phase generator, starting "on" when err_i rises
    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_on_d  = blink_on_q;
        if (!err_i) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b0;
        end else if (!err_q) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (blink_cnt_q == c_blink_last) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
        end
    end

    // Error override blink state registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err_q       <= 1'b0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b0;
        end else begin
            err_q       <= err_i;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end
`endif

    // Display follows the current owner's live pattern one cycle later
    always_comb begin
        display_d = (|gnt_q) ? (w_owner_pat ^ c_pol_mask) : c_leds_off;
`ifdef LED_ARB_ERR_OVERRIDE_EN
        if (err_i) begin
            display_d = blink_on_d ? (err_pat_i ^ c_pol_mask) : c_leds_off;
        end
`endif
    end

    // Arbiter state registers; reset forgets any previous owner
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            gnt_q        <= 4'b0000;
            last_owner_q <= 2'd3;
            pre_q        <= '0;
            dwell_q      <= 16'd0;
            display_q    <= c_leds_off;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_owner_q <= last_owner_d;
            pre_q        <= pre_d;
            dwell_q      <= dwell_d;
            display_q    <= display_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign display_o = display_q;

endmodule
`default_nettype wire

// File: tb/tb_led_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_arbiter
// Brief    : Scoreboard bench for led_arbiter (CLK_IN_MHZ=1, DWELL_MS=2,
//            LED_POLARITY=0, so one dwell is 2000 cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [31:0] pat = 32'h0;
    logic [3:0]  gnt;
    logic [7:0]  disp;
`ifdef LED_ARB_ERR_OVERRIDE_EN
    logic        err = 1'b0;
    logic [7:0]  err_pat = 8'h00;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] gnt;
        logic [7:0] disp;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    led_arbiter #(
        .CLK_IN_MHZ   (1),
        .LED_POLARITY (1'b0),
        .DWELL_MS     (2)
    ) dut (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .req_i     (req),
        .pat_i     (pat),
`ifdef LED_ARB_ERR_OVERRIDE_EN
        .err_i     (err),
        .err_pat_i (err_pat),
`endif
        .gnt_o     (gnt),
        .display_o (disp)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push(input int c, input logic [3:0] g, input logic [7:0] d, input string t);
        exp_t e;
        e.cyc = c; e.gnt = g; e.disp = d; e.tag = t;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req  = 4'b0000;
        sb.delete();
        repeat (3) tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        int   base;
        exp_t e;
        rstn = 1'b0;
        req  = 4'b0000;
        tick();
        n_cmp++;
        if (gnt !== 4'b0000 || disp !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_assert: gnt=%b disp=%h, expected gnt=0000 disp=ff", gnt, disp);
        end
        rstn = 1'b1;
        base = cyc;
        push(base + 1,    4'b0000, 8'hFF, "idle_1");
        push(base + 500,  4'b0000, 8'hFF, "idle_500");
        push(base + 3000, 4'b0000, 8'hFF, "idle_3000");
        repeat (3002) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (e.cyc != cyc || gnt !== e.gnt || disp !== e.disp) begin
                    n_fail++;
                    $display("FAIL %s cyc %0d: gnt=%b disp=%h, expected gnt=%b disp=%h", e.tag, cyc, gnt, disp, e.gnt, e.disp);
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL reset_drain: %0d entries left, expected 0", sb.size());
        end
    endtask

    task automatic test_latency();
        int   base;
        exp_t e;
        do_reset();
        base = cyc;
        req  = 4'b0001;
        pat  = 32'h0000_000F;
        push(base + 1, 4'b0001, 8'hFF, "lat_gnt");
        push(base + 2, 4'b0001, 8'hF0, "lat_disp");
        push(base + 3, 4'b0001, 8'hC3, "live_pat");
        push(base + 4, 4'b0000, 8'hC3, "drop_gnt");
        push(base + 5, 4'b0000, 8'hFF, "drop_disp");
        repeat (8) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (e.cyc != cyc || gnt !== e.gnt || disp !== e.disp) begin
                    n_fail++;
                    $display("FAIL %s cyc %0d: gnt=%b disp=%h, expected gnt=%b disp=%h", e.tag, cyc, gnt, disp, e.gnt, e.disp);
                end
            end
            if (cyc == base + 2) pat = 32'h0000_003C;
            if (cyc == base + 3) req = 4'b0000;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL lat_drain: %0d entries left, expected 0", sb.size());
        end
    endtask

    task automatic test_round_robin();
        int   base;
        bit   gap_bad;
        exp_t e;
        do_reset();
        base    = cyc;
        gap_bad = 1'b0;
        req     = 4'b0011;
        pat     = 32'h4433_2211;
        push(base + 1,    4'b0001, 8'hFF, "rr_first");
        push(base + 2,    4'b0001, 8'hEE, "rr_first_disp");
        push(base + 2000, 4'b0001, 8'hEE, "rr_dwell_end0");
        push(base + 2001, 4'b0010, 8'hEE, "rr_handover1");
        push(base + 2002, 4'b0010, 8'hDD, "rr_disp1");
        push(base + 4000, 4'b0010, 8'hDD, "rr_dwell_end1");
        push(base + 4001, 4'b0001, 8'hDD, "rr_handover0");
        push(base + 4002, 4'b0001, 8'hEE, "rr_disp0");
        repeat (4005) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (e.cyc != cyc || gnt !== e.gnt || disp !== e.disp) begin
                    n_fail++;
                    $display("FAIL %s cyc %0d: gnt=%b disp=%h, expected gnt=%b disp=%h", e.tag, cyc, gnt, disp, e.gnt, e.disp);
                end
            end
            if (!$onehot(gnt)) gap_bad = 1'b1;
        end
        n_cmp++;
        if (gap_bad) begin
            n_fail++;
            $display("FAIL rr_gapless: saw a zero or multi-bit grant, expected one-hot throughout");
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rr_drain: %0d entries left, expected 0", sb.size());
        end
    endtask

    task automatic test_owner_drop();
        int   base;
        exp_t e;
        do_reset();
        base = cyc;
        req  = 4'b0001;
        pat  = 32'h0081_000F;
        push(base + 1,    4'b0001, 8'hFF, "drop_first");
        push(base + 101,  4'b0100, 8'hF0, "drop_handover");
        push(base + 102,  4'b0100, 8'h7E, "drop_disp");
        push(base + 2100, 4'b0100, 8'h7E, "drop_fresh_dwell");
        push(base + 2101, 4'b0001, 8'h7E, "drop_next_owner");
        push(base + 2102, 4'b0001, 8'hF0, "drop_next_disp");
        repeat (2105) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (e.cyc != cyc || gnt !== e.gnt || disp !== e.disp) begin
                    n_fail++;
                    $display("FAIL %s cyc %0d: gnt=%b disp=%h, expected gnt=%b disp=%h", e.tag, cyc, gnt, disp, e.gnt, e.disp);
                end
            end
            if (cyc == base + 1)   req = 4'b0101;
            if (cyc == base + 100) req = 4'b0100;
            if (cyc == base + 101) req = 4'b0101;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drop_drain: %0d entries left, expected 0", sb.size());
        end
    endtask

    task automatic test_hold();
        int   base;
        exp_t e;
        do_reset();
        base = cyc;
        req  = 4'b1000;
        pat  = 32'h1200_0034;
        push(base + 1,     4'b1000, 8'hFF, "hold_first");
        push(base + 2,     4'b1000, 8'hED, "hold_disp");
        push(base + 2001,  4'b1000, 8'hED, "hold_after_dwell");
        push(base + 10000, 4'b1000, 8'hED, "hold_10000");
        push(base + 10001, 4'b0001, 8'hED, "hold_preempt");
        push(base + 10002, 4'b0001, 8'hCB, "hold_preempt_disp");
        repeat (10004) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (e.cyc != cyc || gnt !== e.gnt || disp !== e.disp) begin
                    n_fail++;
                    $display("FAIL %s cyc %0d: gnt=%b disp=%h, expected gnt=%b disp=%h", e.tag, cyc, gnt, disp, e.gnt, e.disp);
                end
            end
            if (cyc == base + 10000) req = 4'b1001;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL hold_drain: %0d entries left, expected 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_dwell();
        int   base;
        exp_t e;
        do_reset();
        base = cyc;
        req  = 4'b0011;
        pat  = 32'h0000_5AA5;
        push(base + 1,  4'b0001, 8'hFF, "mid_first");
        push(base + 53, 4'b0001, 8'hFF, "mid_restart");
        push(base + 54, 4'b0001, 8'h5A, "mid_restart_disp");
        repeat (60) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (e.cyc != cyc || gnt !== e.gnt || disp !== e.disp) begin
                    n_fail++;
                    $display("FAIL %s cyc %0d: gnt=%b disp=%h, expected gnt=%b disp=%h", e.tag, cyc, gnt, disp, e.gnt, e.disp);
                end
            end
            if (cyc == base + 50) begin
                rstn = 1'b0;
                #1;
                n_cmp++;
                if (gnt !== 4'b0000 || disp !== 8'hFF) begin
                    n_fail++;
                    $display("FAIL mid_async_reset: gnt=%b disp=%h, expected gnt=0000 disp=ff", gnt, disp);
                end
            end
            if (cyc == base + 52) rstn = 1'b1;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL mid_drain: %0d entries left, expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_round_robin();
        test_owner_drop();
        test_hold();
        test_reset_mid_dwell();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
